// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that owns the architectural HI/LO
// registers. Sits in EX next to the ALU and uses the same forwarded operands.
// The hazard unit watches busy to stall. mfhi/mflo read HI/LO through the EX
// result mux.
//
// Handshake: an operation is accepted on a rising edge where start=1,
// cancel=0 and busy=0. While busy=1, start is ignored for every MDop. The
// requester must hold the instruction, because nothing is queued. done pulses
// for exactly one cycle, which is the cycle in which the new HI/LO are first
// visible. busy is already 0 in that cycle, so a new start is accepted then.
//
// The arithmetic result is computed combinationally from the operands at accept
// and latched. The countdown then only models the architectural latency, so
// later changes to SrcA/SrcB cannot affect an in-flight result.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  MDop,
  input  logic        start,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_hi_q, res_lo_q;
  logic [31:0]   res_hi_d, res_lo_d;
  logic          latch_res;
  logic          commit;
  logic          move_hi;
  logic          move_lo;
  logic          done_q;

  // ---------------------------------------------------------------------------
  // Arithmetic datapath (evaluated on the live operands, used only at accept)
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quot, rem;

  assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
  assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  // Signed divide is done on magnitudes so truncation toward zero and the
  // dividend-signed remainder fall out naturally. 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0, and no overflow flag is raised.
  assign div_signed = (MDop == OP_DIV);
  assign a_neg      = div_signed & SrcA[31];
  assign b_neg      = div_signed & SrcB[31];
  assign a_mag      = a_neg ? (32'd0 - SrcA) : SrcA;
  assign b_mag      = b_neg ? (32'd0 - SrcB) : SrcB;
  assign b_safe     = (SrcB == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  // Select the HI/LO pair the accepted operation will eventually commit.
  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (MDop)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (SrcB == 32'd0) begin
          // A zero divisor does not trap. HI gets the dividend and LO gets all ones.
          res_hi_d = SrcA;
          res_lo_d = 32'hFFFF_FFFF;
        end else begin
          res_hi_d = rem;
          res_lo_d = quot;
        end
      end
      default: begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // Next-state logic: accept in IDLE, count down while busy, cancel aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_res = 1'b0;
    commit    = 1'b0;
    move_hi   = 1'b0;
    move_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (MDop)
            OP_MULT, OP_MULTU: begin
              state_d   = ST_MUL;
              cnt_d     = MUL_LOAD;
              latch_res = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d   = ST_DIV;
              cnt_d     = DIV_LOAD;
              latch_res = 1'b1;
            end
            OP_MTHI: move_hi = 1'b1;
            OP_MTLO: move_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          // A flush discards the result, so no commit and no done pulse.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched result, architectural HI/LO and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (latch_res) begin
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
      end
      if (commit) begin
        HI <= res_hi_q;
        LO <= res_lo_q;
      end else begin
        if (move_hi) HI <= SrcA;
        if (move_lo) LO <= SrcA;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, table-driven bench for md_unit with hand-computed
// HI/LO values, plus hand-written sequences for stall, cancel and reset cases.
`timescale 1ns/1ps
module tb_md_unit;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  MDop;
  logic        start, cancel;
  logic        busy, done;
  logic [31:0] HI, LO;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  md_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDop(MDop),
    .start(start), .cancel(cancel), .busy(busy), .done(done),
    .HI(HI), .LO(LO), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Hold start for one cycle, then scramble the operands to prove they were latched.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDop  = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk); #1;
    start = 1'b0;
    MDop  = OP_NONE;
    SrcA  = $urandom;
    SrcB  = $urandom;
  endtask

  // Called one cycle after accept. Leaves the bench in the done cycle.
  task automatic wait_done(input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic [31:0] old_hi, input logic [31:0] old_lo, input string nm);
    for (int i = 0; i < lat; i++) begin
      chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      chk({nm, " done early"}, {31'd0, done}, 32'd0);
      chk({nm, " HI hold"}, HI, old_hi);
      chk({nm, " LO hold"}, LO, old_lo);
      @(posedge clk); #1;
    end
    chk({nm, " busy end"}, {31'd0, busy}, 32'd0);
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    chk({nm, " HI"}, HI, ehi);
    chk({nm, " LO"}, LO, elo);
  endtask

  initial begin
    logic [31:0] prev_hi, prev_lo;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; MDop = OP_NONE;
    SrcA = 32'd0; SrcB = 32'd0;

    vecs[0]  = '{OP_MTHI,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'h0000_0000, 0};
    vecs[1]  = '{OP_MTLO,  32'h0000_5678, 32'd0,        32'h0000_1234, 32'h0000_5678, 0};
    vecs[2]  = '{OP_RSVD,  32'hFFFF_FFFF, 32'd9,        32'h0000_1234, 32'h0000_5678, 0};
    vecs[3]  = '{OP_NONE,  32'hFFFF_FFFF, 32'd9,        32'h0000_1234, 32'h0000_5678, 0};
    vecs[4]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MULC};
    vecs[5]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, MULC};
    vecs[6]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULC};
    vecs[7]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIVC};
    vecs[9]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        DIVC};
    vecs[10] = '{OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, DIVC};
    vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIVC};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, DIVC};

    // reset state
    #1;
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven vectors
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < 13; i++) begin
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].lat == 0) begin
        chk($sformatf("vec[%0d] busy", i), {31'd0, busy}, 32'd0);
        chk($sformatf("vec[%0d] done", i), {31'd0, done}, 32'd0);
        chk($sformatf("vec[%0d] HI", i), HI, vecs[i].hi);
        chk($sformatf("vec[%0d] LO", i), LO, vecs[i].lo);
      end else begin
        wait_done(vecs[i].lat, vecs[i].hi, vecs[i].lo, prev_hi, prev_lo,
                  $sformatf("vec[%0d]", i));
        @(posedge clk); #1;
        chk($sformatf("vec[%0d] done pulse", i), {31'd0, done}, 32'd0);
      end
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // mthi issued while busy is ignored and only the mult result lands
    drive_start(OP_MULT, 32'd2, 32'd3);
    chk("stall busy c1", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b1; MDop = OP_MTHI; SrcA = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0; MDop = OP_NONE;
    chk("stall mthi ignored", HI, 32'hFFFF_FFF9);
    for (int i = 0; i < 3; i++) begin
      chk("stall busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("stall done", {31'd0, done}, 32'd1);
    chk("stall HI", HI, 32'd0);
    chk("stall LO", LO, 32'd6);
    @(posedge clk); #1;

    // cancel in cycle 4 of a divide
    drive_start(OP_MTHI, 32'h11, 32'd0);
    drive_start(OP_MTLO, 32'h22, 32'd0);
    drive_start(OP_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("cancel busy before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy drop", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DIVC + 2; i++) begin
      chk("cancel no done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("cancel HI", HI, 32'h11);
    chk("cancel LO", LO, 32'h22);

    // same-cycle start+cancel launches nothing
    start = 1'b1; cancel = 1'b1; MDop = OP_DIV; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    chk("start+cancel busy", {31'd0, busy}, 32'd0);
    MDop = OP_MTHI; SrcA = 32'h99;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; MDop = OP_NONE;
    chk("start+cancel mthi HI", HI, 32'h11);
    chk("start+cancel busy2", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DIVC + 2; i++) begin
      chk("start+cancel no done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("start+cancel LO", LO, 32'h22);

    // async reset in cycle 3 of a mult, then back-to-back multiplies
    drive_start(OP_MTHI, 32'hAAAA, 32'd0);
    drive_start(OP_MTLO, 32'h5555, 32'd0);
    drive_start(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("async rst HI", HI, 32'd0);
    chk("async rst LO", LO, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post rst busy", {31'd0, busy}, 32'd0);
    drive_start(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(MULC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 32'd0, "b2b mult");
    drive_start(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(MULC, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "b2b multu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers, placed in the EX stage beside the ALU.
- Takes the same forwarded SrcA/SrcB operands the ALU uses.
- Its busy flag is consumed by the hazard unit to stall the pipeline.
- HI/LO values are read back by mfhi/mflo through the EX result mux.

Parameters:
MUL_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (>=1)
DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
SrcA  input  32  operand A (rs); dividend for div
SrcB  input  32  operand B (rt); divisor for div
MDop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
start  input  1  qualifies MDop for one cycle
cancel  input  1  exception flush; aborts an in-flight operation
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse in the cycle HI/LO are updated by mult/div
HI  output  32  committed HI register
LO  output  32  committed LO register

Behaviour:
- Reset (async, any time including mid-operation):
  - HI=0, LO=0, busy=0, done=0.
  - FSM to IDLE, counter=0; any operation in flight is discarded.
- FSM states: IDLE, MUL, DIV.
- In IDLE, start=1 with cancel=0:
  - mult/multu: latch the 64-bit product and load counter=MUL_CYCLES-1. Go to MUL; busy=1 from the next cycle.
    - mult: signed product of SrcA*SrcB.
    - multu: zero-extended product.
  - div/divu: latch quotient/remainder and load counter=DIV_CYCLES-1. Go to DIV.
  - mthi: HI<=SrcA at the next edge, single cycle; busy stays 0, done stays 0.
  - mtlo: LO<=SrcA at the next edge, single cycle; busy stays 0, done stays 0.
  - none/reserved: no effect.
- In MUL/DIV:
  - Counter decrements each cycle.
  - At the edge where counter==0: HI<=result[63:32] (or remainder), LO<=result[31:0] (or quotient). done=1 for that following cycle, busy=0, FSM returns to IDLE.
  - Total latency: accept edge to HI/LO-visible edge = MUL_CYCLES or DIV_CYCLES.
- While busy, start is ignored for every MDop, including mthi/mtlo.
  - The hazard unit must stall the instruction instead; HI/LO hold their old values throughout.
- A new start is accepted in the same cycle done=1, since busy is already 0.
- Division arithmetic:
  - div: truncates toward zero; remainder takes the sign of the dividend (-7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF).
  - divu: unsigned.
  - Divisor==0 (div and divu): LO=0xFFFFFFFF, HI=SrcA. No trap.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No overflow flag.
- cancel:
  - While busy: at the next edge FSM goes to IDLE and busy=0. HI/LO unchanged, no done pulse.
  - In IDLE: cancel=1 suppresses a same-cycle start (including mthi/mtlo); cancel wins.
- Operands are latched at accept; later changes to SrcA/SrcB have no effect on the in-flight result.
- HI/LO outputs are registered, never combinational from the operands.

Test Plan:
- Reset, then mult SrcA=0xFFFFFFFE, SrcB=3 -> busy=1 for 5 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- Boundary divides:
  - divu 5/0 -> LO=0xFFFFFFFF, HI=5.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234 then mtlo 0x5678 in consecutive idle cycles -> HI=0x1234, LO=0x5678, busy never asserted. mthi issued while busy -> ignored, HI unchanged after completion except for the mult result.
- Start div, assert cancel at cycle 4 -> busy drops next cycle, no done, HI/LO keep prior values. Same-cycle start+cancel -> nothing launched.
- Assert reset at cycle 3 of a mult after a prior HI/LO=0xAAAA/0x5555 -> HI=0, LO=0, busy=0 immediately (async). After release, a new mult completes normally with back-to-back start in the done cycle.
